mc_mem_responder: RTL and testbench



---
 rtl/mc_mem_responder.sv | 150 +++++++++++++++
 tb/tb_mc_mem_responder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_mem_responder.sv
// Word-addressed RAM responder with programmable wait states.
// Optional misaligned-access flag: define MEM_ALIGN_CHECK_EN.
module mc_mem_responder #(
   parameter int          ADDR_WIDTH  = 8,
   parameter int          WAIT_STATES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] adr,
   input  logic [31:0] tom,
   input  logic [3:0]  be,
   output logic [31:0] fromm,
   output logic        ready,
   output logic        busy,
   output logic        err
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
   localparam logic [CW-1:0] CNT_INIT =
      (WAIT_STATES > 0) ? CW'(WAIT_STATES - 1) : '0;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;

   logic        we_q;
   logic [31:0] adr_q;
   logic [31:0] tom_q;
   logic [3:0]  be_q;

   logic [31:0] ram [DEPTH];

   logic        a_we;
   logic [31:0] a_adr;
   logic [31:0] a_tom;
   logic [3:0]  a_be;
   logic [31:0] off;
   logic        in_rng;
   logic        mis;
   logic        acc;
   logic [ADDR_WIDTH-1:0] idx;
   logic        unused_ok;

   // With zero wait states the access edge is the capture edge
   always_comb begin
      a_we  = we_q;
      a_adr = adr_q;
      a_tom = tom_q;
      a_be  = be_q;
      if (state == IDLE) begin
         a_we  = we;
         a_adr = adr;
         a_tom = tom;
         a_be  = be;
      end
   end

   assign off       = a_adr - BASE_ADDR;
   assign in_rng    = (off[31:ADDR_WIDTH+2] == '0);
   assign idx       = off[ADDR_WIDTH+1:2];
   assign unused_ok = ^off[1:0];

`ifdef MEM_ALIGN_CHECK_EN
   assign mis = |a_adr[1:0];
`else
   assign mis = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      unique case (state)
         IDLE: begin
            if (req) begin
               if (WAIT_STATES == 0) begin
                  state_nx = RESP;
               end else begin
                  state_nx = WAIT;
                  cnt_nx   = CNT_INIT;
               end
            end
         end
         WAIT: begin
            if (cnt == '0) state_nx = RESP;
            else           cnt_nx   = cnt - CW'(1);
         end
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign acc = (state != RESP) && (state_nx == RESP);

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         fromm <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (acc && !a_we) begin
            fromm <= (mis || !in_rng) ? '0 : ram[idx];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset && state == IDLE && req) begin
         we_q  <= we;
         adr_q <= adr;
         tom_q <= tom;
         be_q  <= be;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset && acc && a_we && in_rng && !mis) begin
         for (int i = 0; i < 4; i++) begin
            if (a_be[i]) ram[idx][8*i +: 8] <= a_tom[8*i +: 8];
         end
      end
   end

`ifdef MEM_ALIGN_CHECK_EN
   logic mis_q;

   always_ff @(posedge clock) begin
      if (reset)    mis_q <= 1'b0;
      else if (acc) mis_q <= mis;
   end

   assign err = (state == RESP) && mis_q;
`else
   assign err = 1'b0;
`endif

   assign ready = (state == RESP);
   assign busy  = (state != IDLE);

endmodule

// File: tb/tb_mc_mem_responder.sv
// Random and directed checks of mc_mem_responder against a word-array model.
// Two instances (2 and 0 wait states) share the request fields.
module tb_mc_mem_responder;

   localparam logic [31:0] BASE = 32'h0000_0000;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req2  = 1'b0;
   logic        req0  = 1'b0;
   logic        we    = 1'b0;
   logic [31:0] adr   = '0;
   logic [31:0] tom   = '0;
   logic [3:0]  be    = '0;

   logic [31:0] fromm2, fromm0;
   logic        ready2, ready0;
   logic        busy2, busy0;
   logic        err2, err0;

   always #5 clock = ~clock;

   mc_mem_responder #(
      .ADDR_WIDTH (8),
      .WAIT_STATES(2),
      .BASE_ADDR  (BASE)
   ) u_dut2 (
      .clock(clock),
      .reset(reset),
      .req  (req2),
      .we   (we),
      .adr  (adr),
      .tom  (tom),
      .be   (be),
      .fromm(fromm2),
      .ready(ready2),
      .busy (busy2),
      .err  (err2)
   );

   mc_mem_responder #(
      .ADDR_WIDTH (8),
      .WAIT_STATES(0),
      .BASE_ADDR  (BASE)
   ) u_dut0 (
      .clock(clock),
      .reset(reset),
      .req  (req0),
      .we   (we),
      .adr  (adr),
      .tom  (tom),
      .be   (be),
      .fromm(fromm0),
      .ready(ready0),
      .busy (busy0),
      .err  (err0)
   );

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] mem_m [256];
   logic [31:0] fr2_e = '0;
   logic [31:0] fr0_e = '0;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit misal(input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
      return a[1:0] != 2'b00;
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit in_rng(input logic [31:0] a);
      return (a - BASE) < 32'h400;
   endfunction

   function automatic logic [7:0] widx(input logic [31:0] a);
      logic [31:0] o;
      o = a - BASE;
      return o[9:2];
   endfunction

   function automatic logic [31:0] rd_m(input logic [31:0] a);
      if (misal(a) || !in_rng(a)) return 32'h0;
      return mem_m[widx(a)];
   endfunction

   task automatic wr_m(input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [3:0]  b);
      logic [31:0] w;
      if (misal(a) || !in_rng(a)) return;
      w = mem_m[widx(a)];
      for (int i = 0; i < 4; i++)
         if (b[i]) w[8*i +: 8] = d[8*i +: 8];
      mem_m[widx(a)] = w;
   endtask

   // One request to the selected instances; inputs scrambled after capture
   task automatic xact(input bit e2, input bit e0, input bit w,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [3:0]  b);
      logic [31:0] rv;
      bit          m;
      rv = rd_m(a);
      m  = misal(a);
      @(negedge clock);
      req2 = e2; req0 = e0;
      we = w; adr = a; tom = d; be = b;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clock);
         if (k == 1) begin
            req2 = 1'b0; req0 = 1'b0;
            we  = 1'($urandom);
            adr = $urandom;
            tom = $urandom;
            be  = 4'($urandom);
         end
         if (e2) begin
            chk("ready2", 32'(ready2), 32'(k == 3));
            chk("busy2", 32'(busy2), 32'(k <= 3));
            chk("err2", 32'(err2), 32'((k == 3) && m));
            if (k == 3) begin
               if (!w) fr2_e = rv;
               chk("fromm2", fromm2, fr2_e);
            end
         end
         if (e0) begin
            chk("ready0", 32'(ready0), 32'(k == 1));
            chk("busy0", 32'(busy0), 32'(k <= 1));
            chk("err0", 32'(err0), 32'((k == 1) && m));
            if (k == 1) begin
               if (!w) fr0_e = rv;
               chk("fromm0", fromm0, fr0_e);
            end
         end
      end
      if (w) wr_m(a, d, b);
   endtask

   // Zero-wait instance with req held for four edges
   task automatic hold_rd(input logic [31:0] a);
      logic [31:0] rv;
      rv = rd_m(a);
      @(negedge clock);
      req0 = 1'b1; we = 1'b0; adr = a;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clock);
         if (k == 4) req0 = 1'b0;
         chk("hold_ready0", 32'(ready0), 32'(k == 1 || k == 3));
         if (k == 1 || k == 3) chk("hold_fromm0", fromm0, rv);
      end
      fr0_e = rv;
   endtask

   // Write on the waited instance, reset sampled at edge E0+rk
   task automatic rst_wr(input int rk,
                         input logic [31:0] a,
                         input logic [31:0] d);
      @(negedge clock);
      req2 = 1'b1; we = 1'b1; adr = a; tom = d; be = 4'hF;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clock);
         if (k == 1) begin
            req2 = 1'b0;
            adr  = $urandom;
            tom  = $urandom;
         end
         chk("rst_ready2", 32'(ready2), 32'h0);
         chk("rst_busy2", 32'(busy2), 32'(k <= rk));
         if (k > rk) begin
            chk("rst_fromm2", fromm2, 32'h0);
            chk("rst_fromm0", fromm0, 32'h0);
         end
         if (k == rk) reset = 1'b1;
         if (k == rk + 1) reset = 1'b0;
      end
      fr2_e = '0;
      fr0_e = '0;
      xact(1, 1, 0, a, 0, 4'h0);
   endtask

   initial begin
      logic [31:0] a;
      repeat (3) @(negedge clock);
      chk("rst_ready", 32'({ready2, ready0}), 32'h0);
      chk("rst_busy", 32'({busy2, busy0}), 32'h0);
      chk("rst_err", 32'({err2, err0}), 32'h0);
      chk("rst_fromm2", fromm2, 32'h0);
      chk("rst_fromm0", fromm0, 32'h0);
      reset = 1'b0;

      for (int i = 0; i < 256; i++)
         xact(1, 1, 1, BASE + 32'(i * 4), $urandom, 4'hF);

      xact(1, 1, 1, 32'h10, 32'hCAFEBABE, 4'hF);
      xact(1, 1, 0, 32'h10, 0, 4'h0);
      chk("rd_cafe", fromm2, 32'hCAFEBABE);

      xact(1, 1, 1, 32'h10, 32'h11223344, 4'b0101);
      xact(1, 1, 0, 32'h10, 0, 4'h0);
      chk("bytelane", fromm2, 32'hCA22BA44);
      xact(1, 1, 1, 32'h10, 32'h55667788, 4'b0000);
      xact(1, 1, 0, 32'h10, 0, 4'h0);
      chk("be_zero", fromm0, 32'hCA22BA44);

      xact(0, 1, 0, 32'h10, 0, 4'h0);
      hold_rd(32'h14);

      xact(1, 1, 1, BASE + 32'h400, 32'hFFFFFFFF, 4'hF);
      xact(1, 1, 0, BASE + 32'h400, 0, 4'h0);
      chk("oor_rd", fromm2, 32'h0);
      xact(1, 1, 0, BASE, 0, 4'h0);

      xact(1, 1, 1, 32'h20, 32'h0BADF00D, 4'hF);
      rst_wr(1, 32'h20, 32'hDEADBEEF);
      rst_wr(2, 32'h20, 32'h12345678);
      chk("rst_word", fromm2, 32'h0BADF00D);

      xact(1, 1, 1, 32'h12, 32'hA5A5A5A5, 4'hF);
      xact(1, 1, 0, 32'h10, 0, 4'h0);

      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 7) == 0)
            a = BASE + 32'h400 + $urandom_range(0, 32'hFFFF);
         else
            a = BASE + 32'($urandom_range(0, 32'h3FF));
         xact(1, 1, 1'($urandom), a, $urandom, 4'($urandom));
      end

      chk("end_fromm2", fromm2, fr2_e);
      chk("end_fromm0", fromm0, fr0_e);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
